// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the memory-access stage.
package mem_stage_pkg;

  localparam int XLEN_DEF = 32;

  // funct3 size/sign encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mem_state_t;

  // Low two funct3 bits pick the size; 011/110/111 fall into the word bucket.
  function automatic logic f3_is_byte(input logic [2:0] f3);
    return f3[1:0] == 2'b00;
  endfunction

  function automatic logic f3_is_half(input logic [2:0] f3);
    return f3[1:0] == 2'b01;
  endfunction

  function automatic logic f3_is_word(input logic [2:0] f3);
    return f3[1];
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data aligner: shifts the addressed bytes down to bit 0 and
// sign/zero-extends according to funct3. Purely combinational.
module mem_load_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] i_word,
  input  logic [1:0]      i_off,
  input  logic [2:0]      i_f3,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] shifted;
  logic            sext;

  assign shifted = i_word >> {i_off, 3'b000};
  // f3[2] set means unsigned (BU/HU)
  assign sext    = ~i_f3[2];

  // select width and fill the upper bits
  always_comb begin
    o_data = shifted;
    if (f3_is_byte(i_f3))
      o_data = {{(XLEN-8){sext & shifted[7]}}, shifted[7:0]};
    else if (f3_is_half(i_f3))
      o_data = {{(XLEN-16){sext & shifted[15]}}, shifted[15:0]};
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: runs one load/store on the req/ack data bus per
// instruction, stalling upstream until the bus acknowledges.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic            i_mem_rd,
  input  logic            i_mem_wr,
  input  logic [2:0]      i_f3,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic            o_stall,
  output logic            o_done,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_ld_misaligned,
  output logic            o_st_misaligned,
  output logic            o_d_req,
  output logic            o_d_we,
  output logic [XLEN-1:0] o_d_addr,
  output logic [XLEN-1:0] o_d_wdata,
  output logic [3:0]      o_d_be,
  input  logic            i_d_ack,
  input  logic [XLEN-1:0] i_d_rdata
);

  mem_state_t      state;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic            mem_op, misal, idle, accept;
  logic [3:0]      be_next;
  logic [XLEN-1:0] wdata_next;
  logic [XLEN-1:0] ld_data;

  assign idle   = (state == S_IDLE);
  assign mem_op = i_valid & (i_mem_rd | i_mem_wr);
  assign misal  = (f3_is_half(i_f3) & i_addr[0]) |
                  (f3_is_word(i_f3) & (|i_addr[1:0]));
  assign accept = idle & mem_op & ~misal;

  // rd&wr together is a store, so the wr bit alone steers the flag
  assign o_ld_misaligned = idle & mem_op & ~i_mem_wr & misal;
  assign o_st_misaligned = idle & mem_op &  i_mem_wr & misal;
  assign o_stall         = accept | (state == S_BUSY);

  // store lane replication and byte enables
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = i_wdata;
    if (f3_is_byte(i_f3)) begin
      be_next    = 4'b0001 << i_addr[1:0];
      wdata_next = {4{i_wdata[7:0]}};
    end else if (f3_is_half(i_f3)) begin
      be_next    = 4'b0011 << i_addr[1:0];
      wdata_next = {2{i_wdata[15:0]}};
    end
  end

  mem_load_align #(.XLEN(XLEN)) u_align (
    .i_word (i_d_rdata),
    .i_off  (off_q),
    .i_f3   (f3_q),
    .o_data (ld_data)
  );

  // IDLE -> BUSY on accept, BUSY -> DONE on ack, DONE -> IDLE unconditionally
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= S_IDLE;
      o_d_req   <= 1'b0;
      o_d_we    <= 1'b0;
      o_d_addr  <= '0;
      o_d_wdata <= '0;
      o_d_be    <= '0;
      o_rdata   <= '0;
      o_done    <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          o_done <= 1'b0;
          if (accept) begin
            o_d_req   <= 1'b1;
            o_d_we    <= i_mem_wr;
            o_d_addr  <= {i_addr[XLEN-1:2], 2'b00};
            o_d_wdata <= wdata_next;
            o_d_be    <= be_next;
            f3_q      <= i_f3;
            off_q     <= i_addr[1:0];
            state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (i_d_ack) begin
            o_d_req <= 1'b0;
            o_done  <= 1'b1;
            if (!o_d_we) o_rdata <= ld_data;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          o_done <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          o_d_req <= 1'b0;
          o_done  <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases followed by random load/store traffic
// checked against a byte-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic        d_ack = 1'b0;
  logic [31:0] d_rdata = '0;
  logic        stall, done, ld_mis, st_mis, d_req, d_we;
  logic [31:0] rdata, d_addr, d_wdata;
  logic [3:0]  d_be;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_rdata = '0;

  always #5 clk = ~clk;

  mem_stage dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_mem_rd(mem_rd),
    .i_mem_wr(mem_wr), .i_f3(f3), .i_addr(addr), .i_wdata(wdata),
    .o_stall(stall), .o_done(done), .o_rdata(rdata),
    .o_ld_misaligned(ld_mis), .o_st_misaligned(st_mis),
    .o_d_req(d_req), .o_d_we(d_we), .o_d_addr(d_addr),
    .o_d_wdata(d_wdata), .o_d_be(d_be), .i_d_ack(d_ack),
    .i_d_rdata(d_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- reference model: access size in bytes ----
  function automatic int m_size(input logic [2:0] f);
    case (f)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit m_misal(input logic [31:0] a, input logic [2:0] f);
    return (a % m_size(f)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [2:0] f);
    int o = int'(a % 4);
    logic [3:0] be = '0;
    for (int i = 0; i < 4; i++) be[i] = (i >= o) && (i < o + m_size(f));
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] rs2, input logic [2:0] f);
    logic [31:0] w;
    int s = m_size(f);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % s) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] word, input logic [31:0] a,
                                         input logic [2:0] f);
    int o = int'(a % 4);
    int s = m_size(f);
    logic [31:0] v = '0;
    for (int j = 0; j < s; j++) v = v | (32'(word[8*(o+j) +: 8]) << (8*j));
    if ((f == 3'd0 || f == 3'd1) && v[8*s-1] && s < 4)
      v = v | ~((32'd1 << (8*s)) - 32'd1);
    return v;
  endfunction

  // One instruction through the stage. Entered and left at #1 after a rising edge.
  // busy_extra = number of BUSY cycles before the one carrying the ack.
  task automatic do_op(input bit rd, input bit wr, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] rs2,
                       input logic [31:0] word, input int busy_extra);
    bit mis = m_misal(a, f);
    bit is_ld = rd && !wr;
    valid = 1'b1; mem_rd = rd; mem_wr = wr; f3 = f; addr = a; wdata = rs2;
    #1;
    chk("ld_mis_flag", 32'(ld_mis), 32'(mis && is_ld));
    chk("st_mis_flag", 32'(st_mis), 32'(mis && wr));
    chk("accept_stall", 32'(stall), 32'(!mis));
    @(posedge clk); #1;
    if (mis) begin
      chk("mis_no_req", 32'(d_req), 32'd0);
      chk("mis_no_stall", 32'(stall), 32'd0);
    end else begin
      for (int k = 0; k <= busy_extra; k++) begin
        chk("busy_req", 32'(d_req), 32'd1);
        chk("busy_stall", 32'(stall), 32'd1);
        chk("busy_we", 32'(d_we), 32'(wr));
        chk("busy_addr", d_addr, a & ~32'd3);
        chk("busy_be", 32'(d_be), 32'(m_be(a, f)));
        chk("busy_wdata", d_wdata, m_wdata(rs2, f));
        chk("busy_no_done", 32'(done), 32'd0);
        if (k == busy_extra) begin d_ack = 1'b1; d_rdata = word; end
        else d_rdata = $urandom;
        @(posedge clk); #1;
        d_ack = 1'b0; d_rdata = $urandom;
      end
      if (is_ld) exp_rdata = m_load(word, a, f);
      chk("done_pulse", 32'(done), 32'd1);
      chk("done_no_stall", 32'(stall), 32'd0);
      chk("done_req_low", 32'(d_req), 32'd0);
      chk("done_rdata", rdata, exp_rdata);
      // inputs still presented during DONE must not start a new access
      @(posedge clk); #1;
      chk("post_done_low", 32'(done), 32'd0);
      chk("post_no_reaccept", 32'(d_req), 32'd0);
    end
    valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(d_req), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(d_we), 32'd0);
    chk("rst_addr", d_addr, 32'd0);
    chk("rst_wdata", d_wdata, 32'd0);
    chk("rst_be", 32'(d_be), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // directed loads
    do_op(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    chk("lw_const", rdata, 32'hDEADBEEF);
    do_op(1, 0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0);
    chk("lb_const", rdata, 32'hFFFFFF80);
    do_op(1, 0, 3'b100, 32'h103, 32'h0, 32'h80112233, 1);
    chk("lbu_const", rdata, 32'h00000080);
    do_op(1, 0, 3'b101, 32'h102, 32'h0, 32'hBEEF1234, 2);
    chk("lhu_const", rdata, 32'h0000BEEF);

    // delayed store: five BUSY cycles, rdata untouched
    do_op(0, 1, 3'b000, 32'h201, 32'h000000A5, 32'h0, 4);
    chk("sb_rdata_kept", rdata, 32'h0000BEEF);

    // misaligned
    do_op(0, 1, 3'b010, 32'h102, 32'h12345678, 32'h0, 0);
    do_op(1, 0, 3'b001, 32'h101, 32'h0, 32'h0, 0);

    // non-memory instruction and stray ack in IDLE
    valid = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; d_ack = 1'b1; d_rdata = 32'hFFFFFFFF;
    #1;
    chk("nonmem_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    d_ack = 1'b0; valid = 1'b0;
    chk("nonmem_req", 32'(d_req), 32'd0);
    chk("nonmem_done", 32'(done), 32'd0);
    chk("idle_ack_rdata", rdata, exp_rdata);

    // reset during BUSY abandons the access
    valid = 1'b1; mem_rd = 1'b1; f3 = 3'b010; addr = 32'h300;
    @(posedge clk); #1;
    chk("pre_rst_req", 32'(d_req), 32'd1);
    valid = 1'b0; mem_rd = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_req", 32'(d_req), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    exp_rdata = '0;
    @(posedge clk); #1;
    rst = 1'b1; d_ack = 1'b1; d_rdata = 32'h55555555;
    @(posedge clk); #1;
    d_ack = 1'b0;
    chk("postrst_done", 32'(done), 32'd0);
    chk("postrst_req", 32'(d_req), 32'd0);
    do_op(1, 0, 3'b010, 32'h400, 32'h0, 32'hCAFEF00D, 0);

    // random traffic
    for (int n = 0; n < 60; n++) begin
      bit r, w;
      logic [31:0] a;
      r = 1'($urandom % 2);
      w = r ? ($urandom % 4 == 0) : 1'b1;
      a = $urandom;
      if ($urandom % 2 == 0) a[1:0] = 2'b00;
      do_op(r, w, 3'($urandom % 8), a, $urandom, $urandom, int'($urandom % 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
